// File: rtl/multiplier_pkg.sv
// Shared types and helpers for the multiplier datapath serial link.
package multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RECEIVE = 2'b01,
        DONE    = 2'b10
    } rx_state_e;

    // Bits needed to count 0..n-1 (never less than one bit).
    function automatic int CLogBase2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        if (r == 0) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/serial_word_receiver_if.sv
// Serial link and parallel handshake between the serializer, receiver and consumer.
interface serial_word_receiver_if #(
    parameter int WORD = 8
);
    logic            start;
    logic            serialInput;
    logic            serialValid;
    logic            dataAck;
    logic [WORD-1:0] parallelOutput;
    logic            dataValid;
    logic            busy;
    logic            overrun;

    modport master (
        output start, serialInput, serialValid, dataAck,
        input  parallelOutput, dataValid, busy, overrun
    );

    modport slave (
        input  start, serialInput, serialValid, dataAck,
        output parallelOutput, dataValid, busy, overrun
    );
endinterface

// File: rtl/serial_word_receiver_bit_counter.sv
// Bit counter for the receiver: counts sampled bits, flags the last bit of a word.
module bit_counter
    import multiplier_pkg::*;
#(
    parameter int WORD = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int COUNT_WIDTH = CLogBase2(WORD);
    localparam logic [COUNT_WIDTH-1:0] LAST = COUNT_WIDTH'(WORD - 1);

    logic [COUNT_WIDTH-1:0] count_q, count_d;

    // Clear wins over enable; wrap explicitly so non-power-of-two WORD works.
    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (en_i)
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end

    // Count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    end

    assign tc_o = (count_q == LAST);
endmodule

// File: rtl/serial_word_receiver.sv
// Serial-in, parallel-out receiver: assembles an MSB-first word and hands it
// to the consumer with a valid/acknowledge handshake.
module serial_word_receiver
    import multiplier_pkg::*;
#(
    parameter int WORD_LENGTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    serial_word_receiver_if.slave  bus
);
    localparam int WORD = WORD_LENGTH * 2;

    rx_state_e       state_q, state_d;
    logic [WORD-1:0] asm_q, asm_d;
    logic [WORD-1:0] par_q, par_d;
    logic            ovr_q, ovr_d;
    logic            accept_start;
    logic            shift_en;
    logic            last_bit;
    logic            complete;

    // In DONE a start only counts when it comes with the acknowledge.
    assign accept_start = bus.start && ((state_q != DONE) || bus.dataAck);
    // A start in RECEIVE discards any bit offered in the same cycle.
    assign shift_en     = (state_q == RECEIVE) && bus.serialValid && !bus.start;
    assign complete     = shift_en && last_bit;

    bit_counter #(.WORD(WORD)) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .clr_i (accept_start),
        .en_i  (shift_en),
        .tc_o  (last_bit)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RECEIVE;
            RECEIVE: if (bus.start) state_d = RECEIVE;
                     else if (complete) state_d = DONE;
            DONE:    if (bus.dataAck) state_d = bus.start ? RECEIVE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: assembly shift, word capture, sticky overrun.
    always_comb begin
        asm_d = asm_q;
        par_d = par_q;
        ovr_d = ovr_q;
        if (accept_start)
            asm_d = '0;
        else if (shift_en)
            asm_d = {asm_q[WORD-2:0], bus.serialInput};
        if (complete)
            par_d = {asm_q[WORD-2:0], bus.serialInput};
        // A new word starting takes precedence over a stray bit in DONE.
        if (accept_start)
            ovr_d = 1'b0;
        else if ((state_q == DONE) && bus.serialValid)
            ovr_d = 1'b1;
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            asm_q <= '0;
            par_q <= '0;
            ovr_q <= 1'b0;
        end else begin
            asm_q <= asm_d;
            par_q <= par_d;
            ovr_q <= ovr_d;
        end
    end

    // Outputs are registers or pure state decodes.
    always_comb begin
        bus.parallelOutput = par_q;
        bus.dataValid      = (state_q == DONE);
        bus.busy           = (state_q == RECEIVE);
        bus.overrun        = ovr_q;
    end
endmodule

// File: tb/tb_serial_word_receiver.sv
// Scoreboard bench for serial_word_receiver (WORD_LENGTH=4, WORD=8).
module tb_serial_word_receiver;
    logic clk = 1'b0;
    logic reset;

    serial_word_receiver_if #(.WORD(8)) bus ();

    serial_word_receiver #(.WORD_LENGTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] expq[$];
    logic       dv_prev = 1'b0;
    logic [7:0] mon_exp;
    logic       in_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every new dataValid must deliver the oldest expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (reset && bus.dataValid && !dv_prev) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %0h expected none", bus.parallelOutput);
                end else begin
                    mon_exp = expq.pop_front();
                    chk("word", {24'h0, bus.parallelOutput}, {24'h0, mon_exp});
                end
            end
            dv_prev = reset ? bus.dataValid : 1'b0;
        end
    end

    // Shift the top n bits of w contiguously (no start).
    task automatic bits(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            bus.serialValid = 1'b1;
            bus.serialInput = w[7-i];
            tick;
        end
        bus.serialValid = 1'b0;
    endtask

    // Start (with ack if leaving DONE), then shift w MSB-first with gmin..gmax
    // idle cycles between bits. offer0 puts a bit on the start cycle.
    task automatic send(input logic [7:0] w, input int gmin, input int gmax,
                        input bit from_done, input bit offer0);
        int g;
        bus.start       = 1'b1;
        bus.dataAck     = from_done;
        bus.serialValid = offer0;
        bus.serialInput = 1'($urandom_range(0, 1));
        tick;
        bus.start       = 1'b0;
        bus.dataAck     = 1'b0;
        bus.serialValid = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 1);
        chk("dv_after_start", 32'(bus.dataValid), 0);
        chk("ovr_after_start", 32'(bus.overrun), 0);
        for (int i = 7; i >= 0; i--) begin
            g = (i == 7) ? 0 : $urandom_range(gmax, gmin);
            repeat (g) begin
                bus.serialValid = 1'b0;
                bus.serialInput = 1'($urandom_range(0, 1));
                bus.dataAck     = 1'($urandom_range(0, 1));
                tick;
                chk("dv_in_gap", 32'(bus.dataValid), 0);
                chk("busy_in_gap", 32'(bus.busy), 1);
            end
            bus.dataAck     = 1'b0;
            bus.serialValid = 1'b1;
            bus.serialInput = w[i];
            if (i == 0) expq.push_back(w);
            tick;
            if (i > 0) begin
                chk("dv_mid_word", 32'(bus.dataValid), 0);
                chk("busy_mid_word", 32'(bus.busy), 1);
            end
        end
        bus.serialValid = 1'b0;
        chk("dv_at_end", 32'(bus.dataValid), 1);
        chk("busy_at_end", 32'(bus.busy), 0);
    endtask

    task automatic ack;
        bus.dataAck = 1'b1;
        tick;
        bus.dataAck = 1'b0;
        chk("dv_after_ack", 32'(bus.dataValid), 0);
        chk("busy_after_ack", 32'(bus.busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w;
        reset           = 1'b0;
        bus.start       = 1'b0;
        bus.serialInput = 1'b0;
        bus.serialValid = 1'b0;
        bus.dataAck     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_par", {24'h0, bus.parallelOutput}, 0);
        chk("rst_dv", 32'(bus.dataValid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ovr", 32'(bus.overrun), 0);
        reset = 1'b1;
        tick;

        // Contiguous word: dataValid exactly 8 edges after start.
        send(8'hA5, 0, 0, 0, 0);
        chk("par_A5", {24'h0, bus.parallelOutput}, 32'hA5);
        ack;

        // Alternate-cycle bits: 8th valid bit at E0+15.
        send(8'h3C, 1, 1, 0, 0);
        ack;
        chk("par_held_idle", {24'h0, bus.parallelOutput}, 32'h3C);

        // Restart mid-word; the bit offered with start is dropped.
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        bits(8'hFF, 5);
        chk("par_held_rx", {24'h0, bus.parallelOutput}, 32'h3C);
        send(8'h81, 0, 0, 0, 1);
        chk("par_81", {24'h0, bus.parallelOutput}, 32'h81);
        ack;

        // Overrun while pending, start without ack ignored, then back-to-back.
        send(8'h12, 0, 0, 0, 0);
        bus.serialValid = 1'b1;
        bus.serialInput = 1'b1;
        tick;
        bus.serialValid = 1'b0;
        chk("ovr_set", 32'(bus.overrun), 1);
        chk("ovr_dv", 32'(bus.dataValid), 1);
        chk("ovr_par", {24'h0, bus.parallelOutput}, 32'h12);
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        chk("start_no_ack_dv", 32'(bus.dataValid), 1);
        chk("start_no_ack_ovr", 32'(bus.overrun), 1);
        send(8'hED, 0, 0, 1, 0);
        chk("par_ED", {24'h0, bus.parallelOutput}, 32'hED);
        ack;

        // Asynchronous reset mid-receive.
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        bits(8'hF0, 4);
        #2 reset = 1'b0;
        #1;
        chk("arst_par", {24'h0, bus.parallelOutput}, 0);
        chk("arst_dv", 32'(bus.dataValid), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_ovr", 32'(bus.overrun), 0);
        tick;
        reset = 1'b1;
        tick;
        send(8'h0F, 0, 0, 0, 0);
        chk("par_0F", {24'h0, bus.parallelOutput}, 32'h0F);
        ack;

        // Randomized traffic: gaps, aborts, back-to-back, ignored noise.
        in_done = 1'b0;
        for (int n = 0; n < 40; n++) begin
            w = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) begin
                if (in_done) ack;
                bus.start = 1'b1;
                tick;
                bus.start = 1'b0;
                bits(8'($urandom_range(0, 255)), $urandom_range(1, 7));
                send(w, 0, 2, 0, 1'($urandom_range(0, 1)));
            end else begin
                send(w, 0, 2, in_done, in_done ? 1'b0 : 1'($urandom_range(0, 1)));
            end
            in_done = 1'b1;
            repeat ($urandom_range(0, 2)) begin
                bus.start = 1'($urandom_range(0, 1));
                tick;
                bus.start = 1'b0;
                chk("dv_hold", 32'(bus.dataValid), 1);
            end
            chk("rand_par", {24'h0, bus.parallelOutput}, {24'h0, w});
            chk("rand_ovr", 32'(bus.overrun), 0);
            if ($urandom_range(0, 1) == 1) begin
                ack;
                in_done = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    bus.serialValid = 1'($urandom_range(0, 1));
                    bus.serialInput = 1'($urandom_range(0, 1));
                    bus.dataAck     = 1'($urandom_range(0, 1));
                    tick;
                    chk("idle_busy", 32'(bus.busy), 0);
                    chk("idle_dv", 32'(bus.dataValid), 0);
                end
                bus.serialValid = 1'b0;
                bus.dataAck     = 1'b0;
            end
        end
        if (in_done) ack;
        tick;
        chk("queue_empty", 32'(expq.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
